// File: rtl/worker_feeder.sv
// worker_feeder: read-side sequencer feeding one worker from the vid, dist and loc SRAMs.
// Per batch: reads one vid row, then streams Q*NSUB dist/loc reads (q-major, s-minor)
// under a worker_ready throttle, tagging each returned sub-batch with its vertex/sub index.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, batch_num    one-cycle batch request and its batch number
//   worker_ready        worker accepts a sub-batch next cycle
//   vid_rdata           vid SRAM read data (slot 0 in the low bits)
//   vid_ren/vid_raddr   vid SRAM read port
//   dist_ren/dist_raddr dist SRAM read port
//   loc_ren/loc_raddr   loc SRAM read port
//   sub_valid, cur_vid, vid_idx, sub_idx, vid_last   tagged return data to the worker
//   busy, batch_done    batch status
module worker_feeder #(
    parameter int unsigned Q               = 16,
    parameter int unsigned NSUB            = 16,
    parameter int unsigned VID_BW          = 16,
    parameter int unsigned VID_ADDR_SPACE  = 4,
    parameter int unsigned DIST_ADDR_SPACE = 16,
    parameter int unsigned LOC_ADDR_SPACE  = 4,
    parameter int unsigned BATCH_BW        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BATCH_BW-1:0]          batch_num,
    input  logic                         worker_ready,
    input  logic [Q*VID_BW-1:0]          vid_rdata,
    output logic                         vid_ren,
    output logic [VID_ADDR_SPACE-1:0]    vid_raddr,
    output logic                         dist_ren,
    output logic [DIST_ADDR_SPACE-1:0]   dist_raddr,
    output logic                         loc_ren,
    output logic [LOC_ADDR_SPACE-1:0]    loc_raddr,
    output logic                         sub_valid,
    output logic [VID_BW-1:0]            cur_vid,
    output logic [$clog2(Q)-1:0]         vid_idx,
    output logic [LOC_ADDR_SPACE-1:0]    sub_idx,
    output logic                         vid_last,
    output logic                         busy,
    output logic                         batch_done
);

    localparam int unsigned QW      = $clog2(Q);
    localparam int unsigned VID_LOW = DIST_ADDR_SPACE - LOC_ADDR_SPACE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VID_RD  = 3'd1,
        VID_LAT = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                      state;
    logic [VID_BW-1:0]           row [Q];
    logic [QW-1:0]               q;
    logic [LOC_ADDR_SPACE-1:0]   s;
    // Tag stage travels alongside dist_ren, matching the one-cycle SRAM latency
    logic [QW-1:0]               tag_q;
    logic [LOC_ADDR_SPACE-1:0]   tag_s;
    logic [VID_BW-1:0]           tag_vid;

    // Only the low batch_num bits select a vid row; the rest are intentionally dropped
    logic unused_batch_bits;
    assign unused_batch_bits = ^batch_num[BATCH_BW-1:VID_ADDR_SPACE];

    // Sequencer, address generation and tag pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            q          <= '0;
            s          <= '0;
            tag_q      <= '0;
            tag_s      <= '0;
            tag_vid    <= '0;
            for (int i = 0; i < Q; i++) row[i] <= '0;
            vid_ren    <= 1'b0;
            vid_raddr  <= '0;
            dist_ren   <= 1'b0;
            dist_raddr <= '0;
            loc_ren    <= 1'b0;
            loc_raddr  <= '0;
            sub_valid  <= 1'b0;
            cur_vid    <= '0;
            vid_idx    <= '0;
            sub_idx    <= '0;
            vid_last   <= 1'b0;
            busy       <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    batch_done <= 1'b0;
                    if (start) begin
                        vid_raddr <= batch_num[VID_ADDR_SPACE-1:0];
                        vid_ren   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= VID_RD;
                    end
                end
                VID_RD: begin
                    vid_ren <= 1'b0;
                    state   <= VID_LAT;
                end
                VID_LAT: begin
                    for (int i = 0; i < Q; i++) row[i] <= vid_rdata[i*VID_BW +: VID_BW];
                    q     <= '0;
                    s     <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (worker_ready) begin
                        dist_ren   <= 1'b1;
                        loc_ren    <= 1'b1;
                        dist_raddr <= {row[q][VID_LOW-1:0], s};
                        loc_raddr  <= s;
                        tag_q      <= q;
                        tag_s      <= s;
                        tag_vid    <= row[q];
                        if (s == LOC_ADDR_SPACE'(NSUB - 1)) begin
                            s <= '0;
                            q <= q + QW'(1);
                            if (q == QW'(Q - 1)) state <= DRAIN;
                        end else begin
                            s <= s + LOC_ADDR_SPACE'(1);
                        end
                    end else begin
                        dist_ren <= 1'b0;
                        loc_ren  <= 1'b0;
                    end
                end
                DRAIN: begin
                    dist_ren <= 1'b0;
                    loc_ren  <= 1'b0;
                    // Final tagged beat visible now; done pulse lands in the following cycle
                    if (sub_valid && vid_last && vid_idx == QW'(Q - 1)) begin
                        batch_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    batch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Return-data tagging: valid exactly one cycle after each read enable
            sub_valid <= dist_ren;
            vid_last  <= dist_ren && (tag_s == LOC_ADDR_SPACE'(NSUB - 1));
            if (dist_ren) begin
                cur_vid <= tag_vid;
                vid_idx <= tag_q;
                sub_idx <= tag_s;
            end
        end
    end

endmodule

// File: tb/tb_worker_feeder.sv
module tb_worker_feeder;

    localparam int Q = 16;
    localparam int NSUB = 16;
    localparam int NOSTALL_CYCLES = 261;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   batch_num;
    logic         worker_ready;
    logic [255:0] vid_rdata;
    logic         vid_ren;
    logic [3:0]   vid_raddr;
    logic         dist_ren;
    logic [15:0]  dist_raddr;
    logic         loc_ren;
    logic [3:0]   loc_raddr;
    logic         sub_valid;
    logic [15:0]  cur_vid;
    logic [3:0]   vid_idx;
    logic [3:0]   sub_idx;
    logic         vid_last;
    logic         busy;
    logic         batch_done;

    worker_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_num(batch_num),
        .worker_ready(worker_ready), .vid_rdata(vid_rdata),
        .vid_ren(vid_ren), .vid_raddr(vid_raddr),
        .dist_ren(dist_ren), .dist_raddr(dist_raddr),
        .loc_ren(loc_ren), .loc_raddr(loc_raddr),
        .sub_valid(sub_valid), .cur_vid(cur_vid), .vid_idx(vid_idx),
        .sub_idx(sub_idx), .vid_last(vid_last), .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    // vid SRAM model, one-cycle read latency
    logic [255:0] mem [16];
    always @(posedge clk) if (vid_ren) vid_rdata <= mem[vid_raddr];

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  q;
        logic [3:0]  s;
        logic [15:0] vid;
        logic        last;
    } exp_t;

    exp_t iss_q[$];
    exp_t tag_q[$];

    int checks = 0;
    int errors = 0;
    logic [15:0] issued_addr [256];
    logic [15:0] nostall_addr [256];
    int n_iss, n_sv, n_vl, n_done, done_cyc;
    logic [3:0] seen_vid_raddr;

    // Drive one batch request and score every issue and return beat against the model
    task automatic run_batch(input logic [7:0] bn, input int mode);
        logic [255:0] r;
        exp_t e, g;
        int cyc;
        bit done;
        logic rdy_edge;
        r = mem[bn[3:0]];
        for (int qi = 0; qi < Q; qi++) begin
            for (int si = 0; si < NSUB; si++) begin
                e.vid  = r[qi*16 +: 16];
                e.q    = 4'(qi);
                e.s    = 4'(si);
                e.addr = {e.vid[11:0], e.s};
                e.last = (si == NSUB - 1);
                iss_q.push_back(e);
                tag_q.push_back(e);
            end
        end
        n_iss = 0; n_sv = 0; n_vl = 0; n_done = 0; done_cyc = 0;
        seen_vid_raddr = 4'hx;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_before_start busy=%b want 0", busy); end
        start = 1'b1;
        batch_num = bn;
        worker_ready = 1'b1;
        cyc = 0;
        done = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            rdy_edge = worker_ready;
            start = 1'b0;
            if (mode == 2 && (cyc == 60 || cyc == 61 || cyc == 150)) begin
                start = 1'b1;
                batch_num = 8'h07;
            end
            if (vid_ren) begin
                seen_vid_raddr = vid_raddr;
                checks++;
                if (vid_raddr !== bn[3:0]) begin errors++; $display("FAIL vid_raddr got %h want %h", vid_raddr, bn[3:0]); end
            end
            checks++;
            if (dist_ren !== loc_ren) begin errors++; $display("FAIL ren_align dist=%b loc=%b", dist_ren, loc_ren); end
            if (dist_ren) begin
                checks++;
                if (!rdy_edge) begin errors++; $display("FAIL ren_while_stalled cyc=%0d", cyc); end
                checks++;
                if (iss_q.size() == 0) begin
                    errors++; $display("FAIL extra_issue addr=%h want none", dist_raddr);
                end else begin
                    g = iss_q.pop_front();
                    if (dist_raddr !== g.addr || loc_raddr !== g.s) begin
                        errors++;
                        $display("FAIL issue_addr dist=%h loc=%h want dist=%h loc=%h", dist_raddr, loc_raddr, g.addr, g.s);
                    end
                end
                if (n_iss < 256) issued_addr[n_iss] = dist_raddr;
                n_iss++;
            end
            if (sub_valid) begin
                n_sv++;
                if (vid_last) n_vl++;
                checks++;
                if (tag_q.size() == 0) begin
                    errors++; $display("FAIL extra_sub_valid vid=%h want none", cur_vid);
                end else begin
                    g = tag_q.pop_front();
                    if (cur_vid !== g.vid || vid_idx !== g.q || sub_idx !== g.s || vid_last !== g.last) begin
                        errors++;
                        $display("FAIL tag got vid=%h q=%0d s=%0d last=%b want vid=%h q=%0d s=%0d last=%b",
                                 cur_vid, vid_idx, sub_idx, vid_last, g.vid, g.q, g.s, g.last);
                    end
                end
            end
            if (batch_done) begin
                n_done++;
                done = 1;
                done_cyc = cyc;
            end
            worker_ready = (mode == 0) ? 1'b1 : ~worker_ready;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL batch_timeout done=0 want 1"); end
        checks++;
        if (iss_q.size() != 0 || tag_q.size() != 0) begin
            errors++; $display("FAIL leftover issues=%0d tags=%0d want 0 0", iss_q.size(), tag_q.size());
        end
        iss_q.delete();
        tag_q.delete();
        worker_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; batch_num = '0; worker_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({vid_ren, vid_raddr, dist_ren, dist_raddr, loc_ren, loc_raddr, sub_valid, cur_vid,
             vid_idx, sub_idx, vid_last, busy, batch_done} !== 55'd0) begin
            errors++; $display("FAIL reset_outputs busy=%b dist_ren=%b vid_ren=%b want all 0", busy, dist_ren, vid_ren);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_batch();
        run_batch(8'd3, 0);
        checks++;
        if (seen_vid_raddr !== 4'd3) begin errors++; $display("FAIL full_vid_raddr got %h want 3", seen_vid_raddr); end
        checks++;
        if (issued_addr[0] !== 16'h0100 || issued_addr[1] !== 16'h0101 ||
            issued_addr[15] !== 16'h010F || issued_addr[16] !== 16'h0110) begin
            errors++;
            $display("FAIL full_first_addrs got %h %h %h %h want 0100 0101 010f 0110",
                     issued_addr[0], issued_addr[1], issued_addr[15], issued_addr[16]);
        end
        checks++;
        if (n_iss != 256 || n_sv != 256 || n_vl != 16) begin
            errors++; $display("FAIL full_counts iss=%0d sv=%0d last=%0d want 256 256 16", n_iss, n_sv, n_vl);
        end
        checks++;
        if (done_cyc != NOSTALL_CYCLES) begin errors++; $display("FAIL full_latency got %0d want %0d", done_cyc, NOSTALL_CYCLES); end
        for (int i = 0; i < 256; i++) nostall_addr[i] = issued_addr[i];
        repeat (4) begin
            @(negedge clk);
            if (batch_done) n_done++;
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL full_done_once got %0d want 1", n_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int bad;
        @(negedge clk);
        start = 1'b1; batch_num = 8'd3; worker_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({vid_ren, vid_raddr, dist_ren, dist_raddr, loc_ren, loc_raddr, sub_valid, cur_vid,
             vid_idx, sub_idx, vid_last, busy, batch_done} !== 55'd0) begin
            errors++; $display("FAIL midreset_outputs busy=%b dist_ren=%b sub_valid=%b want all 0", busy, dist_ren, sub_valid);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (sub_valid || batch_done || busy || dist_ren) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_throttle();
        int diff;
        run_batch(8'd3, 1);
        checks++;
        if (n_iss != 256 || n_sv != 256 || n_vl != 16) begin
            errors++; $display("FAIL throttle_counts iss=%0d sv=%0d last=%0d want 256 256 16", n_iss, n_sv, n_vl);
        end
        diff = 0;
        for (int i = 0; i < 256; i++) if (issued_addr[i] !== nostall_addr[i]) diff++;
        checks++;
        if (diff != 0) begin errors++; $display("FAIL throttle_sequence got %0d differing addrs want 0", diff); end
        checks++;
        if (done_cyc <= NOSTALL_CYCLES) begin errors++; $display("FAIL throttle_latency got %0d want >%0d", done_cyc, NOSTALL_CYCLES); end
    endtask

    task automatic test_addr_trunc();
        run_batch(8'h25, 0);
        checks++;
        if (seen_vid_raddr !== 4'h5) begin errors++; $display("FAIL trunc_vid_raddr got %h want 5", seen_vid_raddr); end
        checks++;
        if (issued_addr[5*16+7] !== 16'h1237) begin errors++; $display("FAIL trunc_dist_raddr got %h want 1237", issued_addr[5*16+7]); end
    endtask

    task automatic test_ignored_start();
        run_batch(8'd3, 2);
        repeat (4) begin
            @(negedge clk);
            if (batch_done) n_done++;
        end
        checks++;
        if (n_done != 1 || n_sv != 256) begin errors++; $display("FAIL ignored_start done=%0d sv=%0d want 1 256", n_done, n_sv); end
    endtask

    task automatic test_back_to_back();
        run_batch(8'd3, 0);
        run_batch(8'd4, 0);
        checks++;
        if (seen_vid_raddr !== 4'd4) begin errors++; $display("FAIL b2b_vid_raddr got %h want 4", seen_vid_raddr); end
        checks++;
        if (n_sv != 256 || n_done != 1) begin errors++; $display("FAIL b2b_second sv=%0d done=%0d want 256 1", n_sv, n_done); end
        checks++;
        if (done_cyc != NOSTALL_CYCLES) begin errors++; $display("FAIL b2b_latency got %0d want %0d", done_cyc, NOSTALL_CYCLES); end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < Q; i++) begin
                mem[r][i*16 +: 16] = 16'(16'h0010 + i + ((r == 3) ? 0 : r * 16'h0100));
            end
        end
        mem[5][5*16 +: 16] = 16'hF123;
        vid_rdata = '0;
        test_reset();
        test_full_batch();
        test_mid_reset();
        test_throttle();
        test_addr_trunc();
        test_ignored_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/worker_feeder.md
Name: worker_feeder

Overview:
- Read-side sequencer for one `worker` instance; sits between the vid, dist and loc SRAMs and `worker`.
- Per batch it does three things:
  - reads one vid row (Q vertex IDs) from the vid SRAM;
  - streams NSUB sub-batch reads of the dist and loc SRAMs for each of the Q vertices;
  - tags each returned sub-batch with vertex/sub-batch indices so `worker` can accumulate partition counts and emit next/proposal data.
- Honours a per-cycle `worker_ready` throttle.

Parameters:
- Q, 16, vertex IDs per vid row
- NSUB, 16, sub-batches per vertex (power of 2; equals 2^LOC_ADDR_SPACE)
- VID_BW, 16, bits per vertex ID
- VID_ADDR_SPACE, 4, vid SRAM address bits
- DIST_ADDR_SPACE, 16, dist SRAM address bits
- LOC_ADDR_SPACE, 4, loc SRAM address bits
- BATCH_BW, 8, batch number width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begin batch `batch_num`
- batch_num  in  BATCH_BW  batch to process, sampled with `start`
- worker_ready  in  1  worker accepts a sub-batch next cycle
- vid_rdata  in  Q*VID_BW  vid SRAM read data; slot 0 at [VID_BW-1:0]
- vid_ren  out  1  vid SRAM read enable
- vid_raddr  out  VID_ADDR_SPACE  vid SRAM address
- dist_ren  out  1  dist SRAM read enable
- dist_raddr  out  DIST_ADDR_SPACE  dist SRAM address
- loc_ren  out  1  loc SRAM read enable
- loc_raddr  out  LOC_ADDR_SPACE  loc SRAM address
- sub_valid  out  1  dist/loc rdata valid this cycle
- cur_vid  out  VID_BW  vertex ID of the data currently valid
- vid_idx  out  log2(Q)  slot index of that vertex
- sub_idx  out  LOC_ADDR_SPACE  sub-batch index of that data
- vid_last  out  1  valid data is the last sub-batch of its vertex
- busy  out  1  batch in progress
- batch_done  out  1  one-cycle pulse after the final sub_valid

Behaviour:
- **Clock and reset:** one clock, `clk`; reset `rst_n` is synchronous and active-low.
- **Reset values:** all outputs 0; internal counters 0; FSM in IDLE.
- **Reset mid-batch:** aborts immediately; no further sub_valid; no batch_done.
- **Outputs:** all registered.
- **SRAM model:** read latency 1; data is valid in the cycle after ren=1.
- **FSM states:** IDLE, VID_RD, VID_LAT, STREAM, DRAIN, DONE.
- **IDLE:**
  - start=1: vid_raddr<=batch_num[VID_ADDR_SPACE-1:0], vid_ren<=1, busy<=1, go VID_RD.
  - start while busy is ignored.
- **VID_RD:** vid_ren<=0; go VID_LAT.
- **VID_LAT:** latch vid_rdata into an internal Q-entry row; q=0, s=0; go STREAM.
- **STREAM, issue (worker_ready=1):**
  - dist_ren=loc_ren<=1.
  - dist_raddr<={row[q][DIST_ADDR_SPACE-LOC_ADDR_SPACE-1:0], s}, i.e. the low 12 vid bits concatenated with s.
  - loc_raddr<=s.
  - Increment s; on wrap (s==NSUB-1): s<=0, q<=q+1.
- **STREAM, stall (worker_ready=0):** ren<=0; counters hold.
- **Last issue** (q==Q-1, s==NSUB-1): go DRAIN.
- **Tag pipeline:** a tag pipeline of depth matching the SRAM latency carries (q, s, row[q]).
  - sub_valid=1 exactly one cycle after each dist_ren=1, with cur_vid/vid_idx/sub_idx from the tag.
  - vid_last=1 when tag s==NSUB-1.
  - sub_valid, vid_last and tags are zero/hold when not valid.
- **DRAIN:** ren<=0; waits for the final sub_valid; go DONE.
- **DONE:** batch_done=1 for one cycle, busy<=0; go IDLE.
- **Issue counts:** exactly Q*NSUB=256 issues and 256 sub_valid pulses per batch, regardless of stalls.
- **Ordering:** q-major, s-minor; no skips, no duplicates.
- **Enable alignment:** dist_ren and loc_ren always equal.
- **Batch number:** vid_raddr uses the low VID_ADDR_SPACE bits of batch_num (modulo wrap).
- **Back-to-back batches:** start accepted in the cycle after batch_done (FSM back in IDLE).

Test Plan:
- **Reset:** rst_n=0 mid-STREAM for 1 cycle → all outputs 0 next cycle; IDLE; no batch_done; later start works normally.
- **Full batch, no stall:**
  - Setup: batch_num=3, vid row slots = 0x0010+i, worker_ready=1.
  - Required: vid_raddr=3; 256 consecutive issues.
  - First dist_raddr=0x0100, then 0x0101 .. 0x010F, then 0x0110.
  - sub_valid count 256; vid_last count 16; batch_done exactly once.
  - Start-to-done cycle count constant = fixed overhead + 256.
- **Throttle:** worker_ready toggles 1/0 each cycle → identical address/tag sequence to the no-stall case; no ren while ready=0; 256 sub_valid total.
- **Address truncation:**
  - Setup: vid slot 5 = 0xF123, batch_num=0x25.
  - Required: dist_raddr for q=5,s=7 is 0x1237; vid_raddr=0x5.
- **Ignored start:** start pulses during STREAM → no restart; counters unaffected; a single batch_done.
- **Back-to-back:** second start the cycle after batch_done with batch_num=4 → vid_raddr=4; second batch completes with 256 sub_valid.
